ysyx_22051145_id_pipe: RTL and testbench

//  Registered RV decode stage between IF and EX, replacing the combinational decoder.
//  - Decodes one 32-bit instruction per cycle into register addresses, an XLEN-wide immediate and an op class.
//  - Supports RV32/RV64 and an optional M extension, and flags illegal encodings.
//  - Decoupled from IF and EX by valid/ready handshakes through a 2-entry skid buffer.

---
 rtl/ysyx_22051145_id_pipe_pkg.sv | 50 +++++
 rtl/ysyx_22051145_dec_core.sv | 150 +++++++++++++++
 rtl/ysyx_22051145_id_pipe.sv | 91 +++++++++
 tb/tb_ysyx_22051145_id_pipe.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22051145_id_pipe_pkg.sv
// ysyx_22051145_id_pipe_pkg: opcode, op-class and decoded-bundle definitions for the decode stage
package ysyx_22051145_id_pipe_pkg;

   typedef enum logic [3:0] {
      OPC_ALU     = 4'd0,
      OPC_ALUI    = 4'd1,
      OPC_LOAD    = 4'd2,
      OPC_STORE   = 4'd3,
      OPC_BRANCH  = 4'd4,
      OPC_JAL     = 4'd5,
      OPC_JALR    = 4'd6,
      OPC_LUI     = 4'd7,
      OPC_AUIPC   = 4'd8,
      OPC_CSR     = 4'd9,
      OPC_MULDIV  = 4'd10,
      OPC_SYSTEM  = 4'd11,
      OPC_FENCE   = 4'd12,
      OPC_ILLEGAL = 4'd15
   } opc_e;

   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_MRET   = 32'h3020_0073;
   localparam logic [31:0] INST_NOP    = 32'h0000_0013;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_IMM32  = 7'b0011011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OP32   = 7'b0111011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
      logic       rd_wen;
      opc_e       opc;
      logic       illegal;
      logic       ebreak;
   } dec_t;

endpackage

// File: rtl/ysyx_22051145_dec_core.sv
// ysyx_22051145_dec_core: combinational RV32/RV64 (+optional M) instruction decoder
module ysyx_22051145_dec_core
   import ysyx_22051145_id_pipe_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter bit HAS_M = 1'b1
) (
   input  logic [31:0]     i_inst,
   output logic [XLEN-1:0] o_imm,
   output dec_t            o_dec
);
   localparam bit RV64 = (XLEN == 64);

   logic [6:0]      w_op, w_f7;
   logic [2:0]      w_f3;
   logic [5:0]      w_hi6;
   logic [4:0]      w_rd;
   logic            w_sh_ok, w_legal, w_use_rs1, w_use_rs2, w_use_rd;
   logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm_z, w_imm_sh, w_imm;
   opc_e            w_opc;

   assign w_op  = i_inst[6:0];
   assign w_f3  = i_inst[14:12];
   assign w_f7  = i_inst[31:25];
   assign w_hi6 = i_inst[31:26];
   // a 6-bit shamt only exists on RV64; on RV32 inst[25] must be clear
   assign w_sh_ok = RV64 | ~i_inst[25];

   assign w_imm_i  = XLEN'($signed(i_inst[31:20]));
   assign w_imm_s  = XLEN'($signed({i_inst[31:25], i_inst[11:7]}));
   assign w_imm_b  = XLEN'($signed({i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0}));
   assign w_imm_u  = XLEN'($signed({i_inst[31:12], 12'b0}));
   assign w_imm_j  = XLEN'($signed({i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0}));
   assign w_imm_z  = XLEN'(i_inst[19:15]);
   assign w_imm_sh = RV64 ? XLEN'(i_inst[25:20]) : XLEN'(i_inst[24:20]);

   // per-opcode legality, class, immediate format and register usage
   always_comb begin
      w_legal   = 1'b0;
      w_opc     = OPC_ILLEGAL;
      w_imm     = '0;
      w_use_rs1 = 1'b0;
      w_use_rs2 = 1'b0;
      w_use_rd  = 1'b0;
      case (w_op)
         OP_LUI, OP_AUIPC: begin
            w_legal  = 1'b1;
            w_opc    = (w_op == OP_LUI) ? OPC_LUI : OPC_AUIPC;
            w_imm    = w_imm_u;
            w_use_rd = 1'b1;
         end
         OP_JAL: begin
            w_legal  = 1'b1;
            w_opc    = OPC_JAL;
            w_imm    = w_imm_j;
            w_use_rd = 1'b1;
         end
         OP_JALR: begin
            w_legal   = (w_f3 == 3'd0);
            w_opc     = OPC_JALR;
            w_imm     = w_imm_i;
            w_use_rs1 = 1'b1;
            w_use_rd  = 1'b1;
         end
         OP_BRANCH: begin
            w_legal   = (w_f3 != 3'd2) & (w_f3 != 3'd3);
            w_opc     = OPC_BRANCH;
            w_imm     = w_imm_b;
            w_use_rs1 = 1'b1;
            w_use_rs2 = 1'b1;
         end
         OP_LOAD: begin
            w_legal   = (w_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) | (RV64 & (w_f3 inside {3'd3, 3'd6}));
            w_opc     = OPC_LOAD;
            w_imm     = w_imm_i;
            w_use_rs1 = 1'b1;
            w_use_rd  = 1'b1;
         end
         OP_STORE: begin
            w_legal   = (w_f3 < 3'd3) | (RV64 & (w_f3 == 3'd3));
            w_opc     = OPC_STORE;
            w_imm     = w_imm_s;
            w_use_rs1 = 1'b1;
            w_use_rs2 = 1'b1;
         end
         OP_IMM: begin
            w_legal   = (w_f3 == 3'd1) ? (w_hi6 == 6'd0) & w_sh_ok :
                        (w_f3 == 3'd5) ? ((w_hi6 == 6'd0) | (w_hi6 == 6'b010000)) & w_sh_ok : 1'b1;
            w_opc     = OPC_ALUI;
            w_imm     = (w_f3 == 3'd1 || w_f3 == 3'd5) ? w_imm_sh : w_imm_i;
            w_use_rs1 = 1'b1;
            w_use_rd  = 1'b1;
         end
         OP_IMM32: begin
            w_legal   = RV64 & ((w_f3 == 3'd0) | ((w_f3 == 3'd1) & (w_f7 == 7'd0)) |
                        ((w_f3 == 3'd5) & ((w_f7 == 7'd0) | (w_f7 == 7'b0100000))));
            w_opc     = OPC_ALUI;
            w_imm     = (w_f3 == 3'd0) ? w_imm_i : w_imm_sh;
            w_use_rs1 = 1'b1;
            w_use_rd  = 1'b1;
         end
         OP_OP: begin
            w_legal   = (w_f7 == 7'd0) | ((w_f7 == 7'b0100000) & (w_f3 == 3'd0 || w_f3 == 3'd5)) |
                        (HAS_M & (w_f7 == 7'd1));
            w_opc     = (w_f7 == 7'd1) ? OPC_MULDIV : OPC_ALU;
            w_use_rs1 = 1'b1;
            w_use_rs2 = 1'b1;
            w_use_rd  = 1'b1;
         end
         OP_OP32: begin
            w_legal   = RV64 & (((w_f7 == 7'd0) & (w_f3 inside {3'd0, 3'd1, 3'd5})) |
                        ((w_f7 == 7'b0100000) & (w_f3 == 3'd0 || w_f3 == 3'd5)) |
                        (HAS_M & (w_f7 == 7'd1) & (w_f3 == 3'd0 || w_f3[2])));
            w_opc     = (w_f7 == 7'd1) ? OPC_MULDIV : OPC_ALU;
            w_use_rs1 = 1'b1;
            w_use_rs2 = 1'b1;
            w_use_rd  = 1'b1;
         end
         OP_FENCE: begin
            w_legal   = (w_f3[2:1] == 2'd0);
            w_opc     = OPC_FENCE;
            w_imm     = w_imm_i;
            w_use_rs1 = 1'b1;
            w_use_rd  = 1'b1;
         end
         OP_SYSTEM: begin
            w_legal   = (w_f3 == 3'd0) ? (i_inst == INST_ECALL || i_inst == INST_EBREAK || i_inst == INST_MRET) :
                        (w_f3 != 3'd4);
            w_opc     = (w_f3 == 3'd0) ? OPC_SYSTEM : OPC_CSR;
            w_imm     = w_f3[2] ? w_imm_z : w_imm_i;
            w_use_rs1 = ~w_f3[2];
            w_use_rd  = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_rd  = (w_legal & w_use_rd) ? i_inst[11:7] : 5'd0;
   assign o_imm = w_legal ? w_imm : '0;
   assign o_dec = '{
      rs1:     (w_legal & w_use_rs1) ? i_inst[19:15] : 5'd0,
      rs2:     (w_legal & w_use_rs2) ? i_inst[24:20] : 5'd0,
      rd:      w_rd,
      rd_wen:  (w_rd != 5'd0),
      opc:     w_legal ? w_opc : OPC_ILLEGAL,
      illegal: ~w_legal,
      ebreak:  w_legal & (i_inst == INST_EBREAK)
   };

endmodule

// File: rtl/ysyx_22051145_id_pipe.sv
// ysyx_22051145_id_pipe: registered decode stage with a 2-entry skid buffer between IF and EX
module ysyx_22051145_id_pipe
   import ysyx_22051145_id_pipe_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter bit HAS_M = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush_i,
   input  logic            if_valid_i,
   output logic            if_ready_o,
   input  logic [31:0]     if_inst_i,
   input  logic [XLEN-1:0] if_pc_i,
   output logic            id_valid_o,
   input  logic            id_ready_i,
   output logic [XLEN-1:0] id_pc_o,
   output logic [31:0]     id_inst_o,
   output logic [XLEN-1:0] id_imm_o,
   output logic [4:0]      id_rs1_o,
   output logic [4:0]      id_rs2_o,
   output logic [4:0]      id_rd_o,
   output logic            id_rd_wen_o,
   output logic [3:0]      id_opclass_o,
   output logic            id_illegal_o,
   output logic            id_ebreak_o
);
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      logic [XLEN-1:0] imm;
      dec_t            dec;
   } ent_t;

   ent_t            w_in, r_main, r_skid;
   logic            r_main_v, r_skid_v;
   logic            w_acc, w_main_ld, w_skid_ld;
   logic [XLEN-1:0] w_imm;
   dec_t            w_dec;

   ysyx_22051145_dec_core #(.XLEN(XLEN), .HAS_M(HAS_M)) u_dec (
      .i_inst (if_inst_i),
      .o_imm  (w_imm),
      .o_dec  (w_dec)
   );

   assign w_in = '{pc: if_pc_i, inst: if_inst_i, imm: w_imm, dec: w_dec};
   // skid occupancy alone gates IF, so if_ready_o never depends on id_ready_i
   assign w_acc     = if_valid_i & ~r_skid_v;
   assign w_main_ld = (~r_main_v | id_ready_i) & (r_skid_v | w_acc);
   assign w_skid_ld = w_acc & r_main_v & ~id_ready_i;

   // entry valid bits; flush empties both entries and drops the incoming instruction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_v <= 1'b0;
         r_skid_v <= 1'b0;
      end else if (flush_i) begin
         r_main_v <= 1'b0;
         r_skid_v <= 1'b0;
      end else begin
         r_main_v <= r_skid_v | w_acc | (r_main_v & ~id_ready_i);
         r_skid_v <= r_skid_v ? ~id_ready_i : w_skid_ld;
      end
   end

   // entry payloads; the skid entry is always older than any new input, so it refills main first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main <= '0;
         r_skid <= '0;
      end else begin
         if (w_main_ld) r_main <= r_skid_v ? r_skid : w_in;
         if (w_skid_ld) r_skid <= w_in;
      end
   end

   assign if_ready_o   = ~r_skid_v;
   assign id_valid_o   = r_main_v;
   assign id_pc_o      = r_main.pc;
   assign id_inst_o    = r_main.inst;
   assign id_imm_o     = r_main.imm;
   assign id_rs1_o     = r_main.dec.rs1;
   assign id_rs2_o     = r_main.dec.rs2;
   assign id_rd_o      = r_main.dec.rd;
   assign id_rd_wen_o  = r_main.dec.rd_wen;
   assign id_opclass_o = r_main.dec.opc;
   assign id_illegal_o = r_main.dec.illegal;
   assign id_ebreak_o  = r_main.dec.ebreak;

endmodule

// File: tb/tb_ysyx_22051145_id_pipe.sv
// tb_ysyx_22051145_id_pipe: random and directed checks of the decode stage against a queue + decode model
module tb_ysyx_22051145_id_pipe;
   import ysyx_22051145_id_pipe_pkg::*;

   typedef struct packed {
      logic [63:0] imm;
      logic [4:0]  rs1, rs2, rd;
      logic        wen;
      logic [3:0]  opc;
      logic        ill, eb;
   } exp_t;

   typedef struct {
      logic [31:0] inst;
      logic [63:0] pc;
   } txn_t;

   logic        clk, rst_n, flush, if_valid, id_ready;
   logic [31:0] if_inst;
   logic [63:0] if_pc;

   logic        rdy64, vld64, wen64, ill64, eb64;
   logic [63:0] pc64, imm64;
   logic [31:0] inst64;
   logic [4:0]  rs1_64, rs2_64, rd64;
   logic [3:0]  opc64;

   logic        rdy32, vld32, wen32, ill32, eb32;
   logic [31:0] pc32, imm32, inst32;
   logic [4:0]  rs1_32, rs2_32, rd32;
   logic [3:0]  opc32;

   int   n_chk = 0, n_err = 0;
   txn_t q[$];
   bit   a;

   ysyx_22051145_id_pipe #(.XLEN(64), .HAS_M(1'b1)) u64 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .if_valid_i(if_valid), .if_ready_o(rdy64),
      .if_inst_i(if_inst), .if_pc_i(if_pc), .id_valid_o(vld64), .id_ready_i(id_ready),
      .id_pc_o(pc64), .id_inst_o(inst64), .id_imm_o(imm64), .id_rs1_o(rs1_64), .id_rs2_o(rs2_64),
      .id_rd_o(rd64), .id_rd_wen_o(wen64), .id_opclass_o(opc64), .id_illegal_o(ill64), .id_ebreak_o(eb64)
   );

   ysyx_22051145_id_pipe #(.XLEN(32), .HAS_M(1'b0)) u32 (
      .clk(clk), .rst_n(rst_n), .flush_i(flush), .if_valid_i(if_valid), .if_ready_o(rdy32),
      .if_inst_i(if_inst), .if_pc_i(if_pc[31:0]), .id_valid_o(vld32), .id_ready_i(id_ready),
      .id_pc_o(pc32), .id_inst_o(inst32), .id_imm_o(imm32), .id_rs1_o(rs1_32), .id_rs2_o(rs2_32),
      .id_rd_o(rd32), .id_rd_wen_o(wen32), .id_opclass_o(opc32), .id_illegal_o(ill32), .id_ebreak_o(eb32)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic longint sx(input longint v, input int b);
      return v[b-1] ? v - (longint'(1) << b) : v;
   endfunction

   // reference decode: classify into an instruction format, then derive fields from the format
   function automatic exp_t model(input logic [31:0] in, input bit rv64, input bit m);
      exp_t e;
      byte  f = "X";
      logic [3:0] c = OPC_ILLEGAL;
      int op = int'(in[6:0]), f3 = int'(in[14:12]), f7 = int'(in[31:25]), hi6 = int'(in[31:26]);
      bit sh_ok = rv64 || !in[25];
      e = '0;
      case (op)
         'h37: begin f = "U"; c = OPC_LUI; end
         'h17: begin f = "U"; c = OPC_AUIPC; end
         'h6f: begin f = "J"; c = OPC_JAL; end
         'h67: begin c = OPC_JALR; if (f3 == 0) f = "I"; end
         'h63: begin c = OPC_BRANCH; if (f3 != 2 && f3 != 3) f = "B"; end
         'h03: begin c = OPC_LOAD; if (f3 inside {0, 1, 2, 4, 5} || (rv64 && f3 inside {3, 6})) f = "I"; end
         'h23: begin c = OPC_STORE; if (f3 < 3 || (rv64 && f3 == 3)) f = "S"; end
         'h13: begin
            c = OPC_ALUI;
            if (f3 == 1) f = (hi6 == 0 && sh_ok) ? "H" : "X";
            else if (f3 == 5) f = ((hi6 == 0 || hi6 == 16) && sh_ok) ? "H" : "X";
            else f = "I";
         end
         'h1b: begin
            c = OPC_ALUI;
            if (rv64 && f3 == 0) f = "I";
            else if (rv64 && ((f3 == 1 && f7 == 0) || (f3 == 5 && (f7 == 0 || f7 == 32)))) f = "H";
         end
         'h33: begin
            c = (f7 == 1) ? OPC_MULDIV : OPC_ALU;
            if (f7 == 0 || (f7 == 32 && f3 inside {0, 5}) || (f7 == 1 && m)) f = "R";
         end
         'h3b: begin
            c = (f7 == 1) ? OPC_MULDIV : OPC_ALU;
            if (rv64 && ((f7 == 0 && f3 inside {0, 1, 5}) || (f7 == 32 && f3 inside {0, 5}) ||
                (f7 == 1 && m && f3 inside {0, 4, 5, 6, 7}))) f = "R";
         end
         'h0f: begin c = OPC_FENCE; if (f3 <= 1) f = "I"; end
         'h73: begin
            if (f3 == 0) begin
               c = OPC_SYSTEM;
               if (in == 32'h00000073 || in == 32'h00100073 || in == 32'h30200073) f = "I";
            end else begin
               c = OPC_CSR;
               if (f3 inside {1, 2, 3}) f = "I";
               else if (f3 inside {5, 6, 7}) f = "Z";
            end
         end
         default: f = "X";
      endcase
      if (f == "X") begin
         e.opc = OPC_ILLEGAL;
         e.ill = 1'b1;
         return e;
      end
      e.opc = c;
      if (f inside {"I", "S", "B", "R", "H"}) e.rs1 = in[19:15];
      if (f inside {"R", "S", "B"}) e.rs2 = in[24:20];
      if (f inside {"R", "I", "U", "J", "Z", "H"}) e.rd = in[11:7];
      e.wen = (e.rd != 0);
      case (f)
         "I": e.imm = sx(longint'(in[31:20]), 12);
         "S": e.imm = sx(longint'(in[31:25]) * 32 + longint'(in[11:7]), 12);
         "B": e.imm = sx(longint'(in[31]) * 4096 + longint'(in[7]) * 2048 + longint'(in[30:25]) * 32 + longint'(in[11:8]) * 2, 13);
         "U": e.imm = sx(longint'(in[31:12]) * 4096, 32);
         "J": e.imm = sx(longint'(in[31]) * (1 << 20) + longint'(in[19:12]) * 4096 + longint'(in[20]) * 2048 + longint'(in[30:21]) * 2, 21);
         "Z": e.imm = longint'(in[19:15]);
         "H": e.imm = rv64 ? longint'(in[25:20]) : longint'(in[24:20]);
         default: e.imm = 0;
      endcase
      e.eb = (in == 32'h00100073);
      return e;
   endfunction

   function automatic logic [31:0] rnd_inst();
      logic [6:0]  ops [13];
      logic [31:0] sys [4];
      logic [31:0] w;
      int j;
      ops = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h1b, 7'h33, 7'h3b, 7'h0f, 7'h73};
      sys = '{32'h00000073, 32'h00100073, 32'h30200073, 32'h00000013};
      w = $urandom;
      case ($urandom_range(0, 9))
         0: return w;
         1: return sys[$urandom_range(0, 3)];
         default: begin
            w[6:0] = ops[$urandom_range(0, 12)];
            j = $urandom_range(0, 3);
            if (j == 0) w[31:25] = 7'h00;
            else if (j == 1) w[31:25] = 7'h20;
            else if (j == 2) w[31:25] = 7'h01;
            return w;
         end
      endcase
   endfunction

   task automatic check_state();
      exp_t e;
      check("rdy64", rdy64, q.size() < 2);
      check("vld64", vld64, q.size() > 0);
      check("rdy32", rdy32, q.size() < 2);
      check("vld32", vld32, q.size() > 0);
      if (q.size() > 0) begin
         e = model(q[0].inst, 1'b1, 1'b1);
         check("pc64", pc64, q[0].pc);
         check("inst64", inst64, q[0].inst);
         check("imm64", imm64, e.imm);
         check("rs1_64", rs1_64, e.rs1);
         check("rs2_64", rs2_64, e.rs2);
         check("rd64", rd64, e.rd);
         check("wen64", wen64, e.wen);
         check("opc64", opc64, e.opc);
         check("ill64", ill64, e.ill);
         check("eb64", eb64, e.eb);
         e = model(q[0].inst, 1'b0, 1'b0);
         check("pc32", pc32, q[0].pc[31:0]);
         check("inst32", inst32, q[0].inst);
         check("imm32", imm32, e.imm[31:0]);
         check("rs1_32", rs1_32, e.rs1);
         check("rs2_32", rs2_32, e.rs2);
         check("rd32", rd32, e.rd);
         check("wen32", wen32, e.wen);
         check("opc32", opc32, e.opc);
         check("ill32", ill32, e.ill);
         check("eb32", eb32, e.eb);
      end
   endtask

   // called at a negedge with inputs set; checks outputs, advances one clock and the model
   task automatic cycle(output bit acc);
      bit pop;
      check_state();
      acc = if_valid && q.size() < 2 && !flush;
      pop = q.size() > 0 && id_ready;
      @(posedge clk);
      if (flush) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (acc) q.push_back('{if_inst, if_pc});
      end
      @(negedge clk);
   endtask

   task automatic drive(input bit v, input bit r, input logic [31:0] inst);
      if_valid = v;
      id_ready = r;
      if_inst  = inst;
      if_pc    = {$urandom, $urandom};
   endtask

   task automatic drain();
      drive(1'b0, 1'b1, 32'h0);
      repeat (3) cycle(a);
   endtask

   initial begin
      clk = 0; rst_n = 0; flush = 0; if_valid = 0; id_ready = 0; if_inst = 0; if_pc = 0;
      repeat (2) @(negedge clk);
      check("rst_vld", vld64, 1'b0);
      check("rst_imm", imm64, 64'h0);
      check("rst_pc", pc64, 64'h0);
      check("rst_opc", opc64, 4'h0);
      rst_n = 1;
      @(negedge clk);
      check("rst_rdy", rdy64, 1'b1);

      // addi x1,x0,-1
      drive(1'b1, 1'b1, 32'hfff00093);
      cycle(a);
      drive(1'b0, 1'b1, 32'h0);
      check("t1_vld", vld64, 1'b1);
      check("t1_imm", imm64, 64'hffff_ffff_ffff_ffff);
      check("t1_rd", rd64, 5'd1);
      check("t1_wen", wen64, 1'b1);
      check("t1_rs1", rs1_64, 5'd0);
      check("t1_rs2", rs2_64, 5'd0);
      check("t1_opc", opc64, OPC_ALUI);
      drain();

      // back-to-back A, B, C with EX stalled, then released
      drive(1'b1, 1'b0, 32'h00100093); cycle(a);
      drive(1'b1, 1'b0, 32'h00200113); cycle(a);
      drive(1'b1, 1'b0, 32'h00300193);
      check("t2_rdy", rdy64, 1'b0);
      cycle(a);
      check("t2_c_held", a, 1'b0);
      id_ready = 1;
      a = 0;
      for (int k = 0; k < 8 && !a; k++) cycle(a);
      check("t2_c_acc", a, 1'b1);
      drain();

      // flush with both entries full and a new instruction offered
      drive(1'b1, 1'b0, 32'h00400213); cycle(a);
      drive(1'b1, 1'b0, 32'h00500293); cycle(a);
      drive(1'b1, 1'b0, 32'h00600313);
      flush = 1;
      cycle(a);
      flush = 0;
      drive(1'b0, 1'b1, 32'h0);
      check("t3_vld", vld64, 1'b0);
      check("t3_rdy", rdy64, 1'b1);
      drain();

      // slli x1,x1,32 on both widths
      drive(1'b1, 1'b1, 32'h02009093); cycle(a);
      drive(1'b0, 1'b1, 32'h0);
      check("t4_ill32", ill32, 1'b1);
      check("t4_wen32", wen32, 1'b0);
      check("t4_ill64", ill64, 1'b0);
      check("t4_imm64", imm64, 64'd32);
      check("t4_opc64", opc64, OPC_ALUI);
      cycle(a);

      // mul x3,x1,x2 with and without M
      drive(1'b1, 1'b1, 32'h022081b3); cycle(a);
      drive(1'b0, 1'b1, 32'h0);
      check("t5_ill32", ill32, 1'b1);
      check("t5_rd32", rd32, 5'd0);
      check("t5_opc64", opc64, OPC_MULDIV);
      check("t5_rs1", rs1_64, 5'd1);
      check("t5_rs2", rs2_64, 5'd2);
      check("t5_rd64", rd64, 5'd3);
      cycle(a);

      // asynchronous reset with both entries full
      drive(1'b1, 1'b0, 32'h00700393); cycle(a);
      drive(1'b1, 1'b0, 32'h00800413); cycle(a);
      drive(1'b0, 1'b0, 32'h0);
      rst_n = 0;
      #1;
      check("t6_vld", vld64, 1'b0);
      check("t6_vld32", vld32, 1'b0);
      check("t6_imm", imm64, 64'h0);
      check("t6_pc", pc64, 64'h0);
      check("t6_inst", inst64, 32'h0);
      check("t6_rd", rd64, 5'd0);
      q.delete();
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      check("t6_rdy", rdy64, 1'b1);
      drive(1'b1, 1'b1, 32'h00100073); cycle(a);
      drive(1'b0, 1'b1, 32'h0);
      check("t6_eb", eb64, 1'b1);
      check("t6_opc", opc64, OPC_SYSTEM);
      cycle(a);

      // random traffic with stalls and occasional flushes
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, rnd_inst());
         flush = ($urandom_range(0, 49) == 0);
         cycle(a);
      end
      flush = 0;
      drain();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
